// File: rtl/line_conv_array_if.sv
// Handshake/bus bundle for line_conv_array: control, weight stream, pixel stream,
// psum in/out and status. clk/rst stay outside as plain ports.
interface line_conv_array_if #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int PSUM_WIDTH  = 24,
    parameter int REG_WIDTH   = 32
) ();
    logic                                       i_start;
    logic [REG_WIDTH-1:0]                       i_conf_ctrl;
    logic                                       o_weight_req;
    logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight;
    logic                                       i_weight_val;
    logic                                       o_data_req;
    logic [BIT_WIDTH*NUM_CHANNEL-1:0]           i_data;
    logic                                       i_data_val;
    logic [PSUM_WIDTH*NUM_KERNEL-1:0]           i_psum;
    logic [PSUM_WIDTH*NUM_KERNEL-1:0]           o_psum;
    logic                                       o_psum_val;
    logic                                       i_psum_rdy;
    logic                                       o_done;
    logic                                       o_busy;

    modport slave (
        input  i_start, i_conf_ctrl, i_weight, i_weight_val, i_data, i_data_val,
               i_psum, i_psum_rdy,
        output o_weight_req, o_data_req, o_psum, o_psum_val, o_done, o_busy
    );

    modport master (
        output i_start, i_conf_ctrl, i_weight, i_weight_val, i_data, i_data_val,
               i_psum, i_psum_rdy,
        input  o_weight_req, o_data_req, o_psum, o_psum_val, o_done, o_busy
    );
endinterface

// File: rtl/line_conv_array.sv
// Line convolution engine: NUM_KCPE-tap sliding window over one input line,
// multi-channel/multi-kernel MAC with optional saturating psum accumulation.
module line_conv_array #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int NUM_KCPE    = 3,
    parameter int PSUM_WIDTH  = 24,
    parameter int REG_WIDTH   = 32
) (
    input logic               clk,
    input logic               rst,
    line_conv_array_if.slave  bus
);

    localparam int W_W    = BIT_WIDTH * NUM_CHANNEL * NUM_KERNEL;
    localparam int X_W    = BIT_WIDTH * NUM_CHANNEL;
    localparam int P_ALL  = PSUM_WIDTH * NUM_KERNEL;
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int WIDX_W = (NUM_KCPE > 1) ? $clog2(NUM_KCPE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOADW = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [16:0]       KCPE_17   = 17'(NUM_KCPE);
    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(NUM_KCPE - 1);

    function automatic logic signed [PROD_W-1:0] smul(input logic [BIT_WIDTH-1:0] a,
                                                      input logic [BIT_WIDTH-1:0] b);
        logic signed [PROD_W-1:0] ae;
        logic signed [PROD_W-1:0] be;
        ae = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a};
        be = {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic [PSUM_WIDTH-1:0] sat_add(input logic [PSUM_WIDTH-1:0] a,
                                                      input logic [PSUM_WIDTH-1:0] b);
        logic [PSUM_WIDTH:0] s;
        s = {a[PSUM_WIDTH-1], a} + {b[PSUM_WIDTH-1], b};
        if (s[PSUM_WIDTH] != s[PSUM_WIDTH-1]) begin
            if (s[PSUM_WIDTH]) begin
                return {1'b1, {(PSUM_WIDTH-1){1'b0}}};
            end else begin
                return {1'b0, {(PSUM_WIDTH-1){1'b1}}};
            end
        end else begin
            return s[PSUM_WIDTH-1:0];
        end
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [W_W-1:0]    weight_r [NUM_KCPE];
    logic [X_W-1:0]    win_r    [NUM_KCPE];
    logic [WIDX_W-1:0] wcnt_r;
    logic [15:0]       pix_cnt_r;
    logic [15:0]       line_len_r;
    logic              acc_en_r;
    logic              s0_val_r;
    logic [P_ALL-1:0]  s0_psum_r;
    logic              s1_val_r;
    logic [P_ALL-1:0]  s1_sum_r;
    logic [P_ALL-1:0]  s1_psum_r;
    logic [P_ALL-1:0]  psum_r;
    logic              psum_val_r;
    logic              done_r;
    logic              busy_r;

    logic              enb_s;
    logic              stall_s;
    logic              adv_s;
    logic              data_req_s;
    logic              weight_req_s;
    logic              pix_hs_s;
    logic              w_hs_s;
    logic              start_acc_s;
    logic              win_full_s;
    logic [P_ALL-1:0]  mac_s;
    logic [P_ALL-1:0]  out_nxt_s;
    logic              unused_conf_s;

    assign enb_s         = bus.i_conf_ctrl[0];
    assign stall_s       = psum_val_r & ~bus.i_psum_rdy;
    assign adv_s         = enb_s & ~stall_s;
    assign data_req_s    = (state_r == ST_RUN) & adv_s;
    assign weight_req_s  = (state_r == ST_LOADW) & enb_s;
    assign pix_hs_s      = data_req_s & bus.i_data_val;
    assign w_hs_s        = weight_req_s & bus.i_weight_val;
    // A start in the o_done cycle is dropped so the next line begins one cycle later.
    assign start_acc_s   = (state_r == ST_IDLE) & bus.i_start & ~done_r & enb_s;
    assign win_full_s    = ({1'b0, pix_cnt_r} + 17'd1) >= KCPE_17;
    assign unused_conf_s = ^bus.i_conf_ctrl[15:3];

    assign bus.o_psum       = psum_r;
    assign bus.o_psum_val   = psum_val_r;
    assign bus.o_done       = done_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_data_req   = data_req_s;
    assign bus.o_weight_req = weight_req_s;

    // Multi-tap, multi-channel MAC per kernel on the current window.
    always_comb begin
        logic [PSUM_WIDTH-1:0]    acc_v;
        logic signed [PROD_W-1:0] prod_v;
        mac_s  = {P_ALL{1'b0}};
        acc_v  = {PSUM_WIDTH{1'b0}};
        prod_v = {PROD_W{1'b0}};
        for (int k = 0; k < NUM_KERNEL; k++) begin
            acc_v = {PSUM_WIDTH{1'b0}};
            for (int t = 0; t < NUM_KCPE; t++) begin
                for (int c = 0; c < NUM_CHANNEL; c++) begin
                    prod_v = smul(weight_r[t][(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH],
                                  win_r[t][c*BIT_WIDTH +: BIT_WIDTH]);
                    acc_v  = acc_v + {{(PSUM_WIDTH-PROD_W){prod_v[PROD_W-1]}}, prod_v};
                end
            end
            mac_s[k*PSUM_WIDTH +: PSUM_WIDTH] = acc_v;
        end
    end

    // Saturating accumulation of the registered sums with the captured psum.
    always_comb begin
        out_nxt_s = {P_ALL{1'b0}};
        for (int k = 0; k < NUM_KERNEL; k++) begin
            out_nxt_s[k*PSUM_WIDTH +: PSUM_WIDTH] =
                sat_add(s1_sum_r[k*PSUM_WIDTH +: PSUM_WIDTH], s1_psum_r[k*PSUM_WIDTH +: PSUM_WIDTH]);
        end
    end

    // Line sequencing: IDLE -> (LOAD_W) -> RUN -> DRAIN -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_nxt_s = bus.i_conf_ctrl[2] ? ST_LOADW : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOADW: begin
                if (w_hs_s && (wcnt_r == LAST_WIDX)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOADW;
                end
            end
            ST_RUN: begin
                if ((line_len_r == 16'd0) || (pix_hs_s && ((pix_cnt_r + 16'd1) == line_len_r))) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave once this edge empties the output register and nothing is behind it.
                if (adv_s && !s0_val_r && !s1_val_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, status flags, counters and per-line configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wcnt_r     <= {WIDX_W{1'b0}};
            pix_cnt_r  <= 16'd0;
            line_len_r <= 16'd0;
            acc_en_r   <= 1'b0;
        end else if (enb_s) begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_r == ST_DRAIN) && (state_nxt_s == ST_IDLE);
            if (start_acc_s) begin
                wcnt_r     <= {WIDX_W{1'b0}};
                pix_cnt_r  <= 16'd0;
                line_len_r <= bus.i_conf_ctrl[31:16];
                acc_en_r   <= bus.i_conf_ctrl[1];
            end else begin
                if (w_hs_s) wcnt_r <= wcnt_r + {{(WIDX_W-1){1'b0}}, 1'b1};
                if (pix_hs_s) pix_cnt_r <= pix_cnt_r + 16'd1;
            end
        end
    end

    // Weight taps, loaded in arrival order during LOAD_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_KCPE; t++) weight_r[t] <= {W_W{1'b0}};
        end else if (w_hs_s) begin
            weight_r[wcnt_r] <= bus.i_weight;
        end
    end

    // Window shift register: newest pixel at the top tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_KCPE; t++) win_r[t] <= {X_W{1'b0}};
        end else if (pix_hs_s) begin
            for (int t = 0; t < NUM_KCPE - 1; t++) win_r[t] <= win_r[t+1];
            win_r[NUM_KCPE-1] <= bus.i_data;
        end
    end

    // Two-stage result pipeline, frozen as a whole on stall or enb low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_val_r   <= 1'b0;
            s0_psum_r  <= {P_ALL{1'b0}};
            s1_val_r   <= 1'b0;
            s1_sum_r   <= {P_ALL{1'b0}};
            s1_psum_r  <= {P_ALL{1'b0}};
            psum_r     <= {P_ALL{1'b0}};
            psum_val_r <= 1'b0;
        end else if (adv_s) begin
            s0_val_r   <= pix_hs_s & win_full_s;
            s0_psum_r  <= (pix_hs_s & acc_en_r) ? bus.i_psum : {P_ALL{1'b0}};
            s1_val_r   <= s0_val_r;
            s1_sum_r   <= mac_s;
            s1_psum_r  <= s0_psum_r;
            psum_val_r <= s1_val_r;
            if (s1_val_r) psum_r <= out_nxt_s;
        end
    end

endmodule

// File: tb/tb_line_conv_array.sv
// Scoreboard bench for line_conv_array: a behavioural MAC model pushes expected
// psums on each accepted window-completing pixel; outputs are popped on transfer.
module tb_line_conv_array;
    localparam int BW = 8, NCH = 3, NK = 4, K = 3, PW = 24, RW = 32;
    localparam int W_W = BW*NCH*NK, X_W = BW*NCH, P_ALL = PW*NK;
    localparam longint PMAX = (64'sd1 <<< (PW-1)) - 64'sd1;
    localparam longint PMIN = -(64'sd1 <<< (PW-1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int wm   [K][NK][NCH];
    int wnew [K][NK][NCH];
    int xm   [K][NCH];
    int pix_drv [NCH];
    int psum_drv[NK];
    logic [P_ALL-1:0] expq[$];

    line_conv_array_if #(.BIT_WIDTH(BW), .NUM_CHANNEL(NCH), .NUM_KERNEL(NK),
                         .PSUM_WIDTH(PW), .REG_WIDTH(RW)) bus ();

    line_conv_array #(.BIT_WIDTH(BW), .NUM_CHANNEL(NCH), .NUM_KERNEL(NK), .NUM_KCPE(K),
                      .PSUM_WIDTH(PW), .REG_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W_W-1:0] pack_w(input int t);
        logic [W_W-1:0] v;
        int x;
        v = {W_W{1'b0}};
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < NCH; c++) begin
                x = wnew[t][k][c];
                v[(k*NCH+c)*BW +: BW] = x[BW-1:0];
            end
        return v;
    endfunction

    function automatic logic [X_W-1:0] pack_pix();
        logic [X_W-1:0] v;
        int x;
        v = {X_W{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            x = pix_drv[c];
            v[c*BW +: BW] = x[BW-1:0];
        end
        return v;
    endfunction

    function automatic logic [P_ALL-1:0] pack_psum();
        logic [P_ALL-1:0] v;
        int x;
        v = {P_ALL{1'b0}};
        for (int k = 0; k < NK; k++) begin
            x = psum_drv[k];
            v[k*PW +: PW] = x[PW-1:0];
        end
        return v;
    endfunction

    function automatic logic [P_ALL-1:0] model_out(input bit acc);
        logic [P_ALL-1:0] v;
        longint s;
        v = {P_ALL{1'b0}};
        for (int k = 0; k < NK; k++) begin
            s = 0;
            for (int t = 0; t < K; t++)
                for (int c = 0; c < NCH; c++) s += longint'(wm[t][k][c]) * longint'(xm[t][c]);
            if (acc) s += longint'(psum_drv[k]);
            if (s > PMAX) s = PMAX;
            if (s < PMIN) s = PMIN;
            v[k*PW +: PW] = s[PW-1:0];
        end
        return v;
    endfunction

    task automatic set_pix(input int pmode);
        for (int c = 0; c < NCH; c++) begin
            case (pmode)
                0: pix_drv[c] = c + 1;
                1: pix_drv[c] = (c == 0) ? -128 : ((c == 1) ? 127 : -1);
                2: pix_drv[c] = -(c + 1);
                default: pix_drv[c] = int'($urandom_range(0, 255)) - 128;
            endcase
        end
    endtask

    // One line from i_start to o_done, with optional stall/freeze/reset injection.
    task automatic run_line(input int L, input bit acc, input bit reload, input int pmode,
                            input int wmode, input bit rnd, input int stall_at,
                            input int freeze_at, input int rst_at, input bit chk_lat,
                            input int psum_fix);
        int pi = 0, wi = 0, fill = 0, outs = 0, wreqs = 0, dones = 0;
        int third_edge = -1, first_val = -1, budget, exp_outs;
        bit done_seen = 0, stall_prev = 0, frz_prev = 0, enb_now, rdy;
        logic [P_ALL-1:0] psum_prev = '0;
        logic val_prev = 1'b0, busy_prev = 1'b0;
        budget = 20*L + 200;
        exp_outs = (L >= K) ? (L - K + 1) : 0;
        if (reload)
            for (int t = 0; t < K; t++)
                for (int k = 0; k < NK; k++)
                    for (int c = 0; c < NCH; c++)
                        wnew[t][k][c] = (wmode == 0) ? 1 : int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < NK; k++) psum_drv[k] = psum_fix;
        for (int i = 0; i < budget && !done_seen; i++) begin
            @(negedge clk);
            bus.i_start = (i == 0);
            bus.i_conf_ctrl = {L[15:0], 13'd0, reload, acc, 1'b1};
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                bus.i_data_val = 1'b0;
                bus.i_weight_val = 1'b0;
                #1;
                check_eq("rst_psum", bus.o_psum, 0);
                check_eq("rst_val", bus.o_psum_val, 0);
                check_eq("rst_busy", bus.o_busy, 0);
                check_eq("rst_dreq", bus.o_data_req, 0);
                check_eq("rst_wreq", bus.o_weight_req, 0);
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk); #1;
                    if (bus.o_done) dones++;
                end
                check_eq("rst_no_done", dones, 0);
                for (int t = 0; t < K; t++)
                    for (int k = 0; k < NK; k++)
                        for (int c = 0; c < NCH; c++) wm[t][k][c] = 0;
                expq.delete();
                return;
            end
            enb_now = !(freeze_at >= 0 && i >= freeze_at && i < freeze_at + 3);
            rdy = enb_now && !(stall_at >= 0 && i >= stall_at && i < stall_at + 4)
                  && (!rnd || $urandom_range(0, 3) != 0);
            bus.i_conf_ctrl[0] = enb_now;
            bus.i_psum_rdy = rdy;
            bus.i_weight_val = reload && (wi < K) && (!rnd || $urandom_range(0, 3) != 0);
            if (wi < K) bus.i_weight = pack_w(wi);
            set_pix(pmode);
            bus.i_data = pack_pix();
            bus.i_data_val = (pi < L) && (!rnd || $urandom_range(0, 3) != 0);
            if (rnd) for (int k = 0; k < NK; k++) psum_drv[k] = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW-1));
            bus.i_psum = pack_psum();
            #1;
            if (stall_prev) check_eq("stall_hold", bus.o_psum, psum_prev);
            if (bus.o_psum_val && !rdy) check_eq("stall_dreq", bus.o_data_req, 0);
            if (!enb_now) check_eq("frz_dreq", bus.o_data_req, 0);
            if (frz_prev) begin
                check_eq("frz_busy", bus.o_busy, busy_prev);
                check_eq("frz_val", bus.o_psum_val, val_prev);
                check_eq("frz_psum", bus.o_psum, psum_prev);
            end
            if (bus.o_weight_req) wreqs++;
            if (bus.i_weight_val && bus.o_weight_req) begin
                wm[wi] = wnew[wi];
                wi++;
            end
            if (bus.i_data_val && bus.o_data_req) begin
                for (int t = 0; t < K-1; t++) xm[t] = xm[t+1];
                xm[K-1] = pix_drv;
                pi++;
                fill++;
                if (fill == K) third_edge = cyc + 1;
                if (fill >= K) expq.push_back(model_out(acc));
            end
            if (bus.o_psum_val && first_val < 0) first_val = cyc;
            if (bus.o_psum_val && bus.i_psum_rdy) begin
                check_eq("out_avail", expq.size() != 0, 1);
                if (expq.size() != 0) check_eq("psum", bus.o_psum, expq.pop_front());
                outs++;
            end
            if (bus.o_done) done_seen = 1;
            stall_prev = bus.o_psum_val && !bus.i_psum_rdy;
            frz_prev   = !enb_now;
            psum_prev  = bus.o_psum;
            val_prev   = bus.o_psum_val;
            busy_prev  = bus.o_busy;
        end
        check_eq("done_seen", done_seen, 1);
        check_eq("out_count", outs, exp_outs);
        check_eq("queue_empty", expq.size(), 0);
        if (!reload) check_eq("no_wreq", wreqs, 0);
        if (chk_lat && L >= K) check_eq("latency", first_val - third_edge, 2);
        bus.i_data_val = 1'b0;
        bus.i_weight_val = 1'b0;
        @(negedge clk); #1;
        check_eq("done_pulse", bus.o_done, 0);
        check_eq("idle_busy", bus.o_busy, 0);
    endtask

    initial begin
        int total, L;
        bit first;
        bus.i_start = 1'b0;
        bus.i_conf_ctrl = 32'd1;
        bus.i_weight = '0;
        bus.i_weight_val = 1'b0;
        bus.i_data = '0;
        bus.i_data_val = 1'b0;
        bus.i_psum = '0;
        bus.i_psum_rdy = 1'b1;
        for (int t = 0; t < K; t++)
            for (int k = 0; k < NK; k++)
                for (int c = 0; c < NCH; c++) wm[t][k][c] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_psum", bus.o_psum, 0);
        check_eq("reset_val", bus.o_psum_val, 0);
        check_eq("reset_done", bus.o_done, 0);
        check_eq("reset_busy", bus.o_busy, 0);
        check_eq("reset_dreq", bus.o_data_req, 0);
        check_eq("reset_wreq", bus.o_weight_req, 0);

        // args: L acc reload pmode wmode rnd stall freeze rst lat psum
        run_line(5, 0, 1, 0, 0, 0, -1, -1, -1, 1, 0);
        run_line(5, 1, 0, 0, 0, 0, -1, -1, -1, 1, 100);
        run_line(5, 1, 0, 0, 0, 0, -1, -1, -1, 0, (1 << 23) - 10);
        run_line(5, 1, 0, 2, 0, 0, -1, -1, -1, 0, -(1 << 23) + 10);
        run_line(12, 0, 1, 3, 1, 0, 10, -1, -1, 0, 0);
        run_line(6, 0, 0, 1, 0, 0, -1, -1, -1, 1, 0);
        run_line(2, 0, 0, 0, 0, 0, -1, -1, -1, 0, 0);
        run_line(10, 1, 0, 3, 0, 0, -1, 6, -1, 0, 55);
        run_line(20, 0, 0, 0, 0, 0, -1, -1, 8, 0, 0);

        total = 0;
        first = 1;
        while (total < 1000) begin
            L = int'($urandom_range(1, 150));
            run_line(L, 1'($urandom_range(0, 1)), first || ($urandom_range(0, 3) == 0),
                     3, 1, 1, -1, -1, -1, 0, 0);
            first = 0;
            total += L;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
